keypad_scanner: RTL and testbench
=================================

Name: keypad_scanner

Overview:
- Front-end stage of the calculator. Scans a 4x4 membrane keypad and debounces the contacts.
- Outputs a 4-bit key code plus a debounced "key held" level.
- These feed the control unit's button and is_pressed_next inputs directly. The control unit does its own rising-edge detection, so this block outputs a level, not a pulse.

Parameters:
- SCAN_DIV, 250: clock cycles each column is driven before its rows are sampled (settling time). Must be ≥2.
- DEBOUNCE_SWEEPS, 8: number of consecutive identical full sweeps required before a press or release is committed. Must be ≥1.
- REPEAT_SWEEPS, 64: sweeps between auto-repeats. Used only with KEYPAD_REPEAT_EN.

Ports:
- clock, input, 1: system clock, positive edge.
- reset, input, 1: asynchronous, active-high reset.
- row, input, 4: keypad row lines, active-low (pulled up externally), asynchronous to clock.
- col, output, 4: keypad column drive, active-low, exactly one bit low at any time.
- button, output, 4: debounced key code; holds the last committed code after release.
- is_pressed, output, 1: debounced level, high while a committed key is held.

Behaviour:
- Reset values (asynchronous): col=4'b1110, button=4'h0, is_pressed=0, all counters and sweep registers 0, FSM in RELEASED.
- Key map, row/col -> code:
  - r0: 1 2 3 A(add)
  - r1: 4 5 6 B(sub)
  - r2: 7 8 9 C(mul)
  - r3: F(clear) 0 E(equal) D(div)
- Row synchronisation: row passes through a 2-FF synchroniser before any use.
- Column scan:
  - Column counter advances 0→1→2→3→0 every SCAN_DIV cycles.
  - col is the one-hot-low encoding of the counter.
  - Synchronised rows are sampled on the last cycle of each column slot.
- Sweep = 4 slots = 4*SCAN_DIV cycles.
- Key detection within a sweep:
  - The first key detected is recorded as the sweep candidate, with priority lowest column, then lowest row.
  - Multiple simultaneous keys: the priority winner is recorded; the others are ignored.
  - No key in the sweep: candidate = NONE.
- Sweep end, comparison with the previous sweep's candidate:
  - Equal: stable counter increments, saturating at DEBOUNCE_SWEEPS.
  - Different: stable counter is set to 1.
  - When the stable counter first reaches DEBOUNCE_SWEEPS, the candidate is committed.
- FSM states: RELEASED, PRESSED, GAP.
  - RELEASED + committed valid key: button←code, is_pressed←1, go to PRESSED.
  - PRESSED + committed NONE: is_pressed←0, go to RELEASED; button unchanged.
  - PRESSED + committed different valid key (roll-over): is_pressed←0 and go to GAP for exactly 1 cycle; then button←new code, is_pressed←1, go to PRESSED.
  - The GAP cycle guarantees the downstream edge detector sees the new press.
  - PRESSED + same key recommitted: no change.
- Timing:
  - button and is_pressed change in the same cycle, registered.
  - Press latency from a stable contact is at most (DEBOUNCE_SWEEPS+1) sweeps + 3 cycles.
  - Release latency has the same bound.
- Bounce: any contact chatter shorter than DEBOUNCE_SWEEPS sweeps produces no output change.
- Reset mid-scan or mid-debounce: outputs return to their reset values immediately; no partial commit survives.

Optional Feature:
- KEYPAD_REPEAT_EN defined:
  - In PRESSED, a repeat counter counts sweeps.
  - Every REPEAT_SWEEPS sweeps with the same key held, is_pressed drops for exactly 1 cycle (via GAP), then re-asserts with the same code.
  - The repeat counter clears on any commit or on reset.
- Not defined: no repeat counter and no periodic GAP; one press yields one rising edge.

Decomposition:
- Shared package calc_pkg holds:
  - key code constants KEY_ADD=4'hA, KEY_SUB=4'hB, KEY_MUL=4'hC, KEY_DIV=4'hD, KEY_EQUAL=4'hE, KEY_CLEAR=4'hF;
  - a keymap function (row index, col index) → code;
  - the FSM state encoding.
- The control unit adopts the same key code constants.
- Sub-module keypad_debounce: sweep-candidate compare, stable counter, commit strobe. The top level keeps the scan counter, synchroniser and FSM.

Test Plan (SCAN_DIV=4, DEBOUNCE_SWEEPS=3, REPEAT_SWEEPS=4; sweep = 16 cycles):
- Reset released, no key: col cycles 1110,1101,1011,0111 every 4 cycles; is_pressed=0 and button=0 for 200 cycles.
- Hold r2/c1 ("8") stable from cycle 20: is_pressed rises with button=4'h8 within 67 cycles; release → is_pressed=0 within 67 cycles, button stays 4'h8.
- "5" contact toggling every 20 cycles for 150 cycles: is_pressed never rises.
- Hold "3", then press "A" while "3" is still held, then release "3": is_pressed goes 1→0 for exactly 1 cycle, then 1 with button=4'hA.
- Hold r3/c0 and r3/c2 together: button=4'hF (clear wins by column priority).
- Assert reset while is_pressed=1: is_pressed=0 and button=0 asynchronously, with no clock edge required.
- KEYPAD_REPEAT_EN defined, "7" held 200 cycles: is_pressed gives a 1-cycle low every 64 cycles after the commit; button stays 4'h7.

Source files
------------

// File: rtl/calc_pkg.sv
`default_nettype none
// ----------------------------------------------------------------------------
// calc_pkg: key codes, keymap, key candidate type and FSM encoding.  Rev 1.0
// ----------------------------------------------------------------------------
package calc_pkg;

  localparam logic [3:0] KEY_ADD   = 4'hA;
  localparam logic [3:0] KEY_SUB   = 4'hB;
  localparam logic [3:0] KEY_MUL   = 4'hC;
  localparam logic [3:0] KEY_DIV   = 4'hD;
  localparam logic [3:0] KEY_EQUAL = 4'hE;
  localparam logic [3:0] KEY_CLEAR = 4'hF;

  localparam logic [1:0] ST_RELEASED = 2'd0;
  localparam logic [1:0] ST_PRESSED  = 2'd1;
  localparam logic [1:0] ST_GAP      = 2'd2;

  // All 16 codes are real keys, so "no key" needs its own valid flag.
  typedef struct packed {
    logic       valid;
    logic [3:0] code;
  } key_t;

  localparam key_t KEY_NONE = '0;

  function automatic logic [3:0] keymap(input logic [1:0] row_idx, input logic [1:0] col_idx);
    logic [3:0] code;
    code = 4'h0;
    case ({row_idx, col_idx})
      4'h0: code = 4'h1;
      4'h1: code = 4'h2;
      4'h2: code = 4'h3;
      4'h3: code = KEY_ADD;
      4'h4: code = 4'h4;
      4'h5: code = 4'h5;
      4'h6: code = 4'h6;
      4'h7: code = KEY_SUB;
      4'h8: code = 4'h7;
      4'h9: code = 4'h8;
      4'hA: code = 4'h9;
      4'hB: code = KEY_MUL;
      4'hC: code = KEY_CLEAR;
      4'hD: code = 4'h0;
      4'hE: code = KEY_EQUAL;
      4'hF: code = KEY_DIV;
    endcase
    return code;
  endfunction

endpackage
`default_nettype wire

// File: rtl/keypad_scanner_if.sv
`default_nettype none
// ----------------------------------------------------------------------------
// keypad_scanner_if: keypad lines plus debounced key outputs.  Rev 1.0
// ----------------------------------------------------------------------------
interface keypad_scanner_if;
  logic [3:0] row;
  logic [3:0] col;
  logic [3:0] button;
  logic       is_pressed;

  modport master (input row, output col, output button, output is_pressed);
  modport slave  (output row, input col, input button, input is_pressed);
endinterface
`default_nettype wire

// File: rtl/keypad_debounce.sv
`default_nettype none
// ----------------------------------------------------------------------------
// keypad_debounce: compares sweep candidates and strobes a commit once stable.  Rev 1.0
// ----------------------------------------------------------------------------
module keypad_debounce
  import calc_pkg::*;
#(
  parameter int DEBOUNCE_SWEEPS = 8
) (
  input  logic clock,
  input  logic reset,
  input  logic sweep_end_i,
  input  key_t cand_i,
  output logic commit_o,
  output key_t commit_key_o
);
  localparam int SW = $clog2(DEBOUNCE_SWEEPS + 1);
  localparam logic [SW-1:0] STABLE_MAX = SW'(DEBOUNCE_SWEEPS);

  key_t          prev_q, prev_d;
  logic [SW-1:0] stable_q, stable_d;
  logic          commit_q, commit_d;
  key_t          commit_key_q, commit_key_d;

  always_comb begin
    prev_d       = prev_q;
    stable_d     = stable_q;
    commit_d     = 1'b0;
    commit_key_d = commit_key_q;
    if (sweep_end_i) begin
      prev_d = cand_i;
      if (cand_i == prev_q) begin
        if (stable_q != STABLE_MAX) stable_d = stable_q + 1'b1;
      end else begin
        stable_d = SW'(1);
      end
      // Commit only on the sweep that first reaches the threshold.
      if ((stable_d == STABLE_MAX) && ((cand_i != prev_q) || (stable_q != STABLE_MAX))) begin
        commit_d     = 1'b1;
        commit_key_d = cand_i;
      end
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      prev_q       <= KEY_NONE;
      stable_q     <= '0;
      commit_q     <= 1'b0;
      commit_key_q <= KEY_NONE;
    end else begin
      prev_q       <= prev_d;
      stable_q     <= stable_d;
      commit_q     <= commit_d;
      commit_key_q <= commit_key_d;
    end
  end

  assign commit_o     = commit_q;
  assign commit_key_o = commit_key_q;

endmodule
`default_nettype wire

// File: rtl/keypad_scanner.sv
`default_nettype none
// ----------------------------------------------------------------------------
// keypad_scanner: 4x4 keypad column scan, debounce and press FSM.  Rev 1.0
// Optional auto-repeat: define KEYPAD_REPEAT_EN.
// ----------------------------------------------------------------------------
module keypad_scanner
  import calc_pkg::*;
#(
  parameter int SCAN_DIV        = 250,
  parameter int DEBOUNCE_SWEEPS = 8,
  parameter int REPEAT_SWEEPS   = 64
) (
  input  logic             clock,
  input  logic             reset,
  keypad_scanner_if.master kp
);
  localparam int DW = $clog2(SCAN_DIV);
  localparam logic [DW-1:0] DIV_LAST = DW'(SCAN_DIV - 1);

  if (SCAN_DIV < 2) begin : g_chk_scan_div
    $error("SCAN_DIV must be at least 2");
  end
  if (DEBOUNCE_SWEEPS < 1) begin : g_chk_debounce
    $error("DEBOUNCE_SWEEPS must be at least 1");
  end
  if (REPEAT_SWEEPS < 1) begin : g_chk_repeat
    $error("REPEAT_SWEEPS must be at least 1");
  end

  logic [3:0]    row_s1_q, row_s2_q;
  logic [DW-1:0] div_q;
  logic [1:0]    col_idx_q;
  key_t          cand_q, slot_key;
  logic [1:0]    row_idx;
  logic          slot_end, sweep_end, commit;
  key_t          commit_key;
  logic [1:0]    state_q, state_d;
  logic [3:0]    button_q, button_d, pend_q, pend_d;
  logic          pressed_q, pressed_d;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      row_s1_q <= 4'hF;
      row_s2_q <= 4'hF;
    end else begin
      row_s1_q <= kp.row;
      row_s2_q <= row_s1_q;
    end
  end

  assign slot_end  = (div_q == DIV_LAST);
  assign sweep_end = slot_end && (col_idx_q == 2'd3);

  // Columns are scanned low to high, so the first hit is the column-priority winner.
  always_comb begin
    row_idx = 2'd0;
    for (int i = 3; i >= 0; i--) begin
      if (!row_s2_q[i]) row_idx = 2'(i);
    end
    slot_key = cand_q;
    if (!cand_q.valid && (row_s2_q != 4'hF)) begin
      slot_key.valid = 1'b1;
      slot_key.code  = keymap(row_idx, col_idx_q);
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      div_q     <= '0;
      col_idx_q <= 2'd0;
      cand_q    <= KEY_NONE;
    end else if (slot_end) begin
      div_q     <= '0;
      col_idx_q <= col_idx_q + 2'd1;
      cand_q    <= sweep_end ? KEY_NONE : slot_key;
    end else begin
      div_q <= div_q + 1'b1;
    end
  end

  assign kp.col = ~(4'b0001 << col_idx_q);

  keypad_debounce #(
    .DEBOUNCE_SWEEPS(DEBOUNCE_SWEEPS)
  ) u_debounce (
    .clock       (clock),
    .reset       (reset),
    .sweep_end_i (sweep_end),
    .cand_i      (slot_key),
    .commit_o    (commit),
    .commit_key_o(commit_key)
  );

`ifdef KEYPAD_REPEAT_EN
  localparam int RW = $clog2(REPEAT_SWEEPS + 1);
  localparam logic [RW-1:0] REP_LAST = RW'(REPEAT_SWEEPS - 1);
  logic [RW-1:0] rep_q, rep_d;
`endif

  always_comb begin
    state_d   = state_q;
    button_d  = button_q;
    pressed_d = pressed_q;
    pend_d    = pend_q;
`ifdef KEYPAD_REPEAT_EN
    rep_d     = commit ? '0 : rep_q;
`endif
    case (state_q)
      ST_RELEASED: begin
        if (commit && commit_key.valid) begin
          button_d  = commit_key.code;
          pressed_d = 1'b1;
          state_d   = ST_PRESSED;
        end
      end
      ST_PRESSED: begin
        if (commit) begin
          if (!commit_key.valid) begin
            pressed_d = 1'b0;
            state_d   = ST_RELEASED;
          end else if (commit_key.code != button_q) begin
            pressed_d = 1'b0;
            pend_d    = commit_key.code;
            state_d   = ST_GAP;
          end
        end
`ifdef KEYPAD_REPEAT_EN
        else if (sweep_end) begin
          if (rep_q == REP_LAST) begin
            rep_d     = '0;
            pressed_d = 1'b0;
            pend_d    = button_q;
            state_d   = ST_GAP;
          end else begin
            rep_d = rep_q + 1'b1;
          end
        end
`endif
      end
      // One low cycle so the downstream edge detector sees a fresh press.
      ST_GAP: begin
        button_d  = pend_q;
        pressed_d = 1'b1;
        state_d   = ST_PRESSED;
      end
      default: begin
        pressed_d = 1'b0;
        state_d   = ST_RELEASED;
      end
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q   <= ST_RELEASED;
      button_q  <= 4'h0;
      pressed_q <= 1'b0;
      pend_q    <= 4'h0;
`ifdef KEYPAD_REPEAT_EN
      rep_q     <= '0;
`endif
    end else begin
      state_q   <= state_d;
      button_q  <= button_d;
      pressed_q <= pressed_d;
      pend_q    <= pend_d;
`ifdef KEYPAD_REPEAT_EN
      rep_q     <= rep_d;
`endif
    end
  end

  assign kp.button     = button_q;
  assign kp.is_pressed = pressed_q;

endmodule
`default_nettype wire

// File: tb/tb_keypad_scanner.sv
`default_nettype none
// ----------------------------------------------------------------------------
// tb_keypad_scanner: directed keypad scenarios with a behavioural key matrix.  Rev 1.0
// ----------------------------------------------------------------------------
module tb_keypad_scanner;
  localparam int LAT_MAX = 67;
  localparam int LAT_MIN = 32;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [15:0] held = '0;
  int          checks = 0;
  int          errors = 0;

  logic [15:0] tbl_keys [4] = '{16'h0001, 16'h2000, 16'h4000, 16'h0800};
  logic [3:0]  tbl_code [4] = '{4'h1, 4'h0, 4'hE, 4'hC};

  keypad_scanner_if kp ();

  keypad_scanner #(
    .SCAN_DIV       (4),
    .DEBOUNCE_SWEEPS(3),
    .REPEAT_SWEEPS  (4)
  ) u_dut (
    .clock(clk),
    .reset(rst),
    .kp   (kp)
  );

  always #5 clk = ~clk;

  // Key at row r, column c is bit r*4+c; it pulls its row low while its column is driven.
  always_comb begin
    kp.row = 4'hF;
    for (int r = 0; r < 4; r++) begin
      for (int c = 0; c < 4; c++) begin
        if (held[r*4+c] && !kp.col[c]) kp.row[r] = 1'b0;
      end
    end
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic wait_pressed(input logic lvl, input int max_cyc, output int cyc);
    cyc = 0;
    while (kp.is_pressed !== lvl && cyc <= max_cyc) begin
      @(negedge clk);
      cyc++;
    end
  endtask

  task automatic tap(input string tag, input logic [15:0] keys, input logic [3:0] exp);
    int cyc;
    held = keys;
    wait_pressed(1'b1, LAT_MAX, cyc);
    check({tag, "_press_lat"}, 32'(cyc <= LAT_MAX && cyc >= LAT_MIN), 32'd1);
    check({tag, "_code"}, 32'(kp.button), 32'(exp));
    held = '0;
    wait_pressed(1'b0, LAT_MAX, cyc);
    check({tag, "_release_lat"}, 32'(cyc <= LAT_MAX && cyc >= LAT_MIN), 32'd1);
    check({tag, "_hold_code"}, 32'(kp.button), 32'(exp));
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int         cyc;
    int         bad;
    int         lows;
    int         first_low;
    int         second_low;
    int         run;
    int         max_run;
    logic [3:0] exp_col;

    tick(3);
    check("rst_col", 32'(kp.col), 32'hE);
    check("rst_button", 32'(kp.button), 32'h0);
    check("rst_pressed", 32'(kp.is_pressed), 32'h0);
    rst = 1'b0;

    for (int k = 0; k < 16; k++) begin
      exp_col = 4'b0001 << ((k / 4) % 4);
      exp_col = ~exp_col;
      check("col_seq", 32'(kp.col), 32'(exp_col));
      @(negedge clk);
    end

    bad = 0;
    repeat (200) begin
      @(negedge clk);
      if (kp.is_pressed !== 1'b0 || kp.button !== 4'h0) bad++;
    end
    check("idle_quiet", bad, 0);

    tap("key8", 16'h0200, 4'h8);
    for (int i = 0; i < 4; i++) tap("keymap", tbl_keys[i], tbl_code[i]);

    bad = 0;
    for (int t = 0; t < 8; t++) begin
      held = (t % 2 == 0) ? 16'h0020 : 16'h0000;
      repeat (20) begin
        @(negedge clk);
        if (kp.is_pressed !== 1'b0) bad++;
      end
    end
    held = '0;
    check("bounce_no_press", bad, 0);
    tick(80);

    tap("multi_clear", 16'h5000, 4'hF);
    tap("multi_row", 16'h0088, 4'hA);

`ifndef KEYPAD_REPEAT_EN
    held = 16'h0004;
    wait_pressed(1'b1, LAT_MAX, cyc);
    check("roll_first", 32'(kp.button), 32'h3);
    held = 16'h000C;
    tick(48);
    check("roll_both_pressed", 32'(kp.is_pressed), 32'h1);
    check("roll_both_code", 32'(kp.button), 32'h3);
    held = 16'h0008;
    wait_pressed(1'b0, LAT_MAX, cyc);
    check("roll_gap_lat", 32'(cyc <= LAT_MAX), 32'd1);
    check("roll_gap_code", 32'(kp.button), 32'h3);
    tick(1);
    check("roll_gap_one_cycle", 32'(kp.is_pressed), 32'h1);
    check("roll_new_code", 32'(kp.button), 32'hA);
    held = '0;
    wait_pressed(1'b0, LAT_MAX, cyc);
    check("roll_release_code", 32'(kp.button), 32'hA);
`endif

    held = 16'h0100;
    wait_pressed(1'b1, LAT_MAX, cyc);
    check("hold7_press", 32'(kp.is_pressed), 32'h1);
    lows = 0; first_low = -1; second_low = -1; run = 0; max_run = 0; bad = 0;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (kp.button !== 4'h7) bad++;
      if (kp.is_pressed === 1'b0) begin
        lows++;
        run++;
        if (run > max_run) max_run = run;
        if (first_low < 0) first_low = i;
        else if (second_low < 0 && run == 1) second_low = i;
      end else begin
        run = 0;
      end
    end
    check("hold7_code", bad, 0);
`ifdef KEYPAD_REPEAT_EN
    check("repeat_count", lows, 3);
    check("repeat_width", max_run, 1);
    check("repeat_period", second_low - first_low, 64);
`else
    check("hold7_no_repeat", lows, 0);
`endif

    check("pre_reset_pressed", 32'(kp.is_pressed), 32'h1);
    #2 rst = 1'b1;
    #1;
    check("async_rst_pressed", 32'(kp.is_pressed), 32'h0);
    check("async_rst_button", 32'(kp.button), 32'h0);
    check("async_rst_col", 32'(kp.col), 32'hE);
    held = '0;
    tick(3);
    rst = 1'b0;
    bad = 0;
    repeat (100) begin
      @(negedge clk);
      if (kp.is_pressed !== 1'b0 || kp.button !== 4'h0) bad++;
    end
    check("post_rst_quiet", bad, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
